// File: rtl/i2c_eeprom_pkg.sv
// Shared types and constants for the I2C EEPROM target model.
package i2c_eeprom_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StDevAddr,
        StAckDev,
        StAddrH,
        StAckAh,
        StAddrL,
        StAckAl,
        StWrData,
        StAckWr,
        StRdData,
        StRdAck,
        StWaitBus
    } state_e;

    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into clk and decodes START, STOP and SCL edge pulses.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_s,
    output logic start,
    output logic stop,
    output logic scl_rise,
    output logic scl_fall
);
    import i2c_eeprom_pkg::*;

    logic [SYNC_DEPTH-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_DEPTH-1:0] sda_sync_q, sda_sync_d;
    logic                  scl_prev_q, scl_prev_d;
    logic                  sda_prev_q, sda_prev_d;
    logic                  scl_s;

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_DEPTH-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_DEPTH-2:0], sda_i};
        scl_s      = scl_sync_q[SYNC_DEPTH-1];
        sda_s      = sda_sync_q[SYNC_DEPTH-1];
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
        // SDA edges only count as bus conditions while SCL stays high across them
        start      = scl_prev_q & scl_s & sda_prev_q & ~sda_s;
        stop       = scl_prev_q & scl_s & ~sda_prev_q & sda_s;
        scl_rise   = ~scl_prev_q & scl_s;
        scl_fall   = scl_prev_q & ~scl_s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

endmodule

// File: rtl/i2c_eeprom_target.sv
// I2C target emulating a two-address-byte serial EEPROM; never stretches SCL.
// Optional write-protect input enabled by defining I2C_EEPROM_WP_EN.
module i2c_eeprom_target #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h50,
    parameter int unsigned ADDR_W     = 11,
    parameter int unsigned PAGE_BYTES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl_i,
    input  logic              sda_i,
`ifdef I2C_EEPROM_WP_EN
    input  logic              wp,
`endif
    output logic              sda_o,
    output logic              sda_oe,
    output logic              busy,
    output logic              wr_pulse,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data
);
    import i2c_eeprom_pkg::*;

    localparam int unsigned       Depth    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PageMask = ADDR_W'(PAGE_BYTES - 1);

    state_e            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              oe_q, oe_d;
    logic              busy_q, busy_d;
    logic              wr_pulse_q, wr_pulse_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              rw_q, rw_d;
    logic              phase_q, phase_d;

    logic [7:0] mem_q [Depth];

    logic       sda_s, start, stop, scl_rise, scl_fall;
    logic       rx_state, byte_done, mem_we, wp_block;
    logic [7:0] rx_byte, rd_byte;

    i2c_bus_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda_s    (sda_s),
        .start    (start),
        .stop     (stop),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall)
    );

`ifdef I2C_EEPROM_WP_EN
    assign wp_block = wp;
`else
    assign wp_block = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        wr_pulse_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rw_d       = rw_q;
        phase_d    = phase_q;
        mem_we     = 1'b0;
        rx_byte    = {shift_q[6:0], sda_s};
        rd_byte    = mem_q[ptr_q];
        rx_state   = (state_q == StDevAddr) || (state_q == StAddrH) ||
                     (state_q == StAddrL) || (state_q == StWrData);
        byte_done  = rx_state && scl_rise && (bit_cnt_q == 4'd7);

        if (start) begin
            state_d   = StDevAddr;
            bit_cnt_d = 4'd0;
            oe_d      = 1'b0;
            busy_d    = 1'b0;
            phase_d   = 1'b0;
        end else if (stop) begin
            state_d = StIdle;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            phase_d = 1'b0;
        end else begin
            if (rx_state && scl_rise) begin
                shift_d   = rx_byte;
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
            case (state_q)
                StDevAddr: if (byte_done) begin
                    if (rx_byte[7:1] == SLAVE_ADDR) begin
                        state_d = StAckDev;
                        rw_d    = rx_byte[0];
                        busy_d  = 1'b1;
                    end else begin
                        state_d = StWaitBus;
                    end
                end
                StAddrH: if (byte_done) begin
                    ptr_d[ADDR_W-1:8] = rx_byte[ADDR_W-9:0];
                    state_d           = StAckAh;
                end
                StAddrL: if (byte_done) begin
                    ptr_d[7:0] = rx_byte;
                    state_d    = StAckAl;
                end
                StWrData: if (byte_done) begin
                    if (wp_block) begin
                        state_d = StWaitBus;
                        busy_d  = 1'b0;
                    end else begin
                        mem_we     = 1'b1;
                        wr_pulse_d = 1'b1;
                        wr_addr_d  = ptr_q;
                        wr_data_d  = rx_byte;
                        // page write: only the in-page offset advances
                        ptr_d      = (ptr_q & ~PageMask) | ((ptr_q + ADDR_W'(1)) & PageMask);
                        state_d    = StAckWr;
                    end
                end
                StAckDev, StAckAh, StAckAl, StAckWr: if (scl_fall) begin
                    if (!phase_q) begin
                        oe_d    = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        oe_d      = 1'b0;
                        phase_d   = 1'b0;
                        bit_cnt_d = 4'd0;
                        case (state_q)
                            StAckDev: begin
                                if (rw_q) begin
                                    shift_d = rd_byte;
                                    oe_d    = ~rd_byte[7];
                                    state_d = StRdData;
                                end else begin
                                    state_d = StAddrH;
                                end
                            end
                            StAckAh: state_d = StAddrL;
                            default: state_d = StWrData;
                        endcase
                    end
                end
                StRdData: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            oe_d    = 1'b0;
                            phase_d = 1'b0;
                            state_d = StRdAck;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oe_d    = ~shift_q[6];
                        end
                    end
                end
                StRdAck: begin
                    if (scl_rise) begin
                        if (sda_s == ACK) begin
                            ptr_d   = ptr_q + ADDR_W'(1);
                            phase_d = 1'b1;
                        end else begin
                            state_d = StWaitBus;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall && phase_q) begin
                        shift_d   = rd_byte;
                        oe_d      = ~rd_byte[7];
                        bit_cnt_d = 4'd0;
                        phase_d   = 1'b0;
                        state_d   = StRdData;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            ptr_q      <= '0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'd0;
            rw_q       <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            wr_pulse_q <= wr_pulse_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rw_q       <= rw_d;
            phase_q    <= phase_d;
        end
    end

    // Contents survive reset by design.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[ptr_q] <= rx_byte;
        end
    end

    assign sda_o    = 1'b0;
    assign sda_oe   = oe_q;
    assign busy     = busy_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule
